// File: rtl/riscv_pkg.sv
// Shared widths and types for the register-read / issue stage.
package riscv_pkg;

    localparam int XLEN   = 64;
    localparam int NREG   = 32;
    localparam int REG_AW = $clog2(NREG);
    localparam int CTRL_W = 32;

    typedef logic [REG_AW-1:0] reg_addr_t;
    typedef logic [XLEN-1:0]   xdata_t;
    typedef logic [CTRL_W-1:0] ctrl_t;   // opaque decoded-control bundle

endpackage

// File: rtl/operand_fetch_scoreboard.sv
// Per-register busy bits: one outstanding write per architectural register.
// x0 is never tracked. A same-register set and clear in one cycle leaves the bit set.
module scoreboard
    import riscv_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            set_en,
    input  reg_addr_t       set_rd,
    input  logic            clr_en,
    input  reg_addr_t       clr_rd,
    output logic [NREG-1:0] busy
);

    // Set on issue to execute, clear on writeback; set has priority.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy <= '0;
        end else begin
            for (int i = 1; i < NREG; i++) begin
                if (set_en && set_rd == reg_addr_t'(i))
                    busy[i] <= 1'b1;
                else if (clr_en && clr_rd == reg_addr_t'(i))
                    busy[i] <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/operand_fetch.sv
// Register-read / issue stage: reads three sources (with writeback bypass),
// stalls RAW/WAW hazards against the busy scoreboard, and registers the
// instruction into a single valid/ready slot for execute.
module operand_fetch
    import riscv_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    // decode side
    input  logic      id_valid,
    output logic      id_ready,
    input  reg_addr_t id_rs1,
    input  reg_addr_t id_rs2,
    input  reg_addr_t id_rs3,
    input  logic      id_use1,
    input  logic      id_use2,
    input  logic      id_use3,
    input  reg_addr_t id_rd,
    input  logic      id_rd_we,
    input  ctrl_t     id_ctrl,
    // register file read ports
    output reg_addr_t rf_r1_addr,
    output reg_addr_t rf_r2_addr,
    output reg_addr_t rf_r3_addr,
    input  xdata_t    rf_r1_data,
    input  xdata_t    rf_r2_data,
    input  xdata_t    rf_r3_data,
    // writeback bus
    input  logic      wb_valid,
    input  reg_addr_t wb_rd,
    input  xdata_t    wb_data,
    // execute side
    input  logic      flush,
    output logic      ex_valid,
    input  logic      ex_ready,
    output xdata_t    ex_op1,
    output xdata_t    ex_op2,
    output xdata_t    ex_op3,
    output reg_addr_t ex_rd,
    output logic      ex_rd_we,
    output ctrl_t     ex_ctrl
);

    logic [NREG-1:0]         busy;
    logic [2:0][REG_AW-1:0]  rs;
    logic [2:0]              src_use;
    logic [2:0][XLEN-1:0]    rfd;
    logic [2:0][XLEN-1:0]    opv;
    logic [2:0]              byp;
    logic                    hazard;
    logic                    accept;
    logic                    handoff;

    assign rs         = {id_rs3, id_rs2, id_rs1};
    assign src_use    = {id_use3, id_use2, id_use1};
    assign rfd        = {rf_r3_data, rf_r2_data, rf_r1_data};

    assign rf_r1_addr = id_rs1;
    assign rf_r2_addr = id_rs2;
    assign rf_r3_addr = id_rs3;

    // Source muxes (x0 > bypass > regfile) and hazard detection.
    // A RAW on a busy register is forgiven when its writeback is on the bus now;
    // WAW has no such escape, so the new write waits for the old one to retire.
    always_comb begin
        opv    = '0;
        byp    = '0;
        hazard = id_rd_we && (id_rd != '0) && busy[id_rd];
        for (int i = 0; i < 3; i++) begin
            byp[i] = wb_valid && (wb_rd == rs[i]);
            if (rs[i] == '0)
                opv[i] = '0;
            else if (byp[i])
                opv[i] = wb_data;
            else
                opv[i] = rfd[i];
            if (src_use[i] && (rs[i] != '0) && busy[rs[i]] && !byp[i])
                hazard = 1'b1;
        end
    end

    assign id_ready = (!ex_valid || ex_ready) && !hazard && !flush;
    assign accept   = id_valid && id_ready;
    assign handoff  = ex_valid && ex_ready;

    // Execute slot: flush > accept > handoff > hold. Payload only moves on accept,
    // so it stays stable under backpressure.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_valid <= 1'b0;
            ex_op1   <= '0;
            ex_op2   <= '0;
            ex_op3   <= '0;
            ex_rd    <= '0;
            ex_rd_we <= 1'b0;
            ex_ctrl  <= '0;
        end else if (flush) begin
            ex_valid <= 1'b0;
        end else if (accept) begin
            ex_valid <= 1'b1;
            ex_op1   <= opv[0];
            ex_op2   <= opv[1];
            ex_op3   <= opv[2];
            ex_rd    <= id_rd;
            ex_rd_we <= id_rd_we;
            ex_ctrl  <= id_ctrl;
        end else if (handoff) begin
            ex_valid <= 1'b0;
        end
    end

    // Busy is marked only once execute owns the instruction (handoff, even
    // alongside flush); a slot killed before handoff never marks anything.
    scoreboard u_sb (
        .clk    (clk),
        .rst    (rst),
        .set_en (handoff && ex_rd_we && (ex_rd != '0)),
        .set_rd (ex_rd),
        .clr_en (wb_valid && (wb_rd != '0)),
        .clr_rd (wb_rd),
        .busy   (busy)
    );

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch: table of single-issue operand-mux vectors,
// then hand sequences for hazards, backpressure, flush and async reset.
module tb_operand_fetch;

    logic        clk;
    logic        rst;
    logic        id_valid, id_ready;
    logic [4:0]  id_rs1, id_rs2, id_rs3, id_rd;
    logic        id_use1, id_use2, id_use3, id_rd_we;
    logic [31:0] id_ctrl;
    logic [4:0]  rf_r1_addr, rf_r2_addr, rf_r3_addr;
    logic [63:0] rf_r1_data, rf_r2_data, rf_r3_data;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [63:0] wb_data;
    logic        flush, ex_valid, ex_ready, ex_rd_we;
    logic [63:0] ex_op1, ex_op2, ex_op3;
    logic [4:0]  ex_rd;
    logic [31:0] ex_ctrl;

    logic [63:0] rf_mem [32];
    int checks = 0;
    int fails  = 0;

    assign rf_r1_data = rf_mem[rf_r1_addr];
    assign rf_r2_data = rf_mem[rf_r2_addr];
    assign rf_r3_data = rf_mem[rf_r3_addr];

    operand_fetch dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_ready(id_ready),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs3(id_rs3),
        .id_use1(id_use1), .id_use2(id_use2), .id_use3(id_use3),
        .id_rd(id_rd), .id_rd_we(id_rd_we), .id_ctrl(id_ctrl),
        .rf_r1_addr(rf_r1_addr), .rf_r2_addr(rf_r2_addr), .rf_r3_addr(rf_r3_addr),
        .rf_r1_data(rf_r1_data), .rf_r2_data(rf_r2_data), .rf_r3_data(rf_r3_data),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .flush(flush), .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_op1(ex_op1), .ex_op2(ex_op2), .ex_op3(ex_op3),
        .ex_rd(ex_rd), .ex_rd_we(ex_rd_we), .ex_ctrl(ex_ctrl)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  rs1, rs2, rs3;
        logic [2:0]  use_m;
        logic [4:0]  rd;
        logic        wbv;
        logic [4:0]  wbrd;
        logic [63:0] wbd;
        logic [31:0] ctrl;
        logic [63:0] e1, e2, e3;
    } vec_t;

    vec_t vt [6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rs3 = 0;
        id_use1 = 0; id_use2 = 0; id_use3 = 0;
        id_rd = 0; id_rd_we = 0; id_ctrl = 0;
        wb_valid = 0; wb_rd = 0; wb_data = 0;
        flush = 0; ex_ready = 1;
    endtask

    task automatic issue(input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] r3,
                         input logic [2:0] u, input logic [4:0] rd, input logic we,
                         input logic [31:0] c);
        id_valid = 1; id_rs1 = r1; id_rs2 = r2; id_rs3 = r3;
        {id_use3, id_use2, id_use1} = u;
        id_rd = rd; id_rd_we = we; id_ctrl = c;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf_mem[i] = 64'h1000 + 64'(i);
        rf_mem[0] = 64'hFF;
        rf_mem[1] = 64'd5;
        rf_mem[2] = 64'd7;

        //          rs1    rs2    rs3    use     rd     wbv   wbrd   wbd         ctrl      e1          e2          e3
        vt[0] = '{5'd1,  5'd2,  5'd3,  3'b111, 5'd11, 1'b0, 5'd0,  64'h0,      32'hA0, 64'd5,      64'd7,      64'h1003};
        vt[1] = '{5'd0,  5'd0,  5'd0,  3'b111, 5'd12, 1'b0, 5'd0,  64'h0,      32'hA1, 64'h0,      64'h0,      64'h0};
        vt[2] = '{5'd5,  5'd6,  5'd7,  3'b111, 5'd13, 1'b1, 5'd6,  64'hDEAD,   32'hA2, 64'h1005,   64'hDEAD,   64'h1007};
        vt[3] = '{5'd9,  5'd9,  5'd9,  3'b111, 5'd14, 1'b1, 5'd9,  64'hBEEF,   32'hA3, 64'hBEEF,   64'hBEEF,   64'hBEEF};
        vt[4] = '{5'd0,  5'd4,  5'd0,  3'b010, 5'd15, 1'b1, 5'd0,  64'h55,     32'hA4, 64'h0,      64'h1004,   64'h0};
        vt[5] = '{5'd31, 5'd30, 5'd29, 3'b000, 5'd16, 1'b0, 5'd31, 64'h77,     32'hA5, 64'h101F,   64'h101E,   64'h101D};

        // Reset state, checked before any clock edge.
        idle();
        rst = 1;
        #2 rst = 0;
        #1;
        chk("rst_ex_valid", ex_valid, 0);
        chk("rst_busy", dut.u_sb.busy, 0);
        chk("rst_ex_ctrl", ex_ctrl, 0);
        chk("rst_ex_op1", ex_op1, 0);
        chk("rst_id_ready", id_ready, 1);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1;
        tick();

        // Operand-mux vectors: one issue each, handoff on the following edge.
        for (int k = 0; k < 6; k++) begin
            issue(vt[k].rs1, vt[k].rs2, vt[k].rs3, vt[k].use_m, vt[k].rd, 1'b0, vt[k].ctrl);
            wb_valid = vt[k].wbv; wb_rd = vt[k].wbrd; wb_data = vt[k].wbd;
            #1;
            chk($sformatf("v%0d_ready", k), id_ready, 1);
            tick();
            idle();
            chk($sformatf("v%0d_valid", k), ex_valid, 1);
            chk($sformatf("v%0d_op1", k), ex_op1, vt[k].e1);
            chk($sformatf("v%0d_op2", k), ex_op2, vt[k].e2);
            chk($sformatf("v%0d_op3", k), ex_op3, vt[k].e3);
            chk($sformatf("v%0d_ctrl", k), ex_ctrl, vt[k].ctrl);
            chk($sformatf("v%0d_rd", k), ex_rd, vt[k].rd);
            tick();
        end
        chk("vec_busy", dut.u_sb.busy, 0);

        // Back-to-back independent issues.
        issue(5'd1, 5'd2, 5'd0, 3'b011, 5'd3, 1'b1, 32'h1111);
        #1 chk("b2b_ready", id_ready, 1);
        tick();
        issue(5'd2, 5'd1, 5'd0, 3'b011, 5'd10, 1'b0, 32'h2222);
        chk("b2b_op1", ex_op1, 64'd5);
        chk("b2b_op2", ex_op2, 64'd7);
        chk("b2b_rd_we", ex_rd_we, 1);
        chk("b2b_busy_pre", dut.u_sb.busy, 0);
        #1 chk("b2b_ready2", id_ready, 1);
        tick();
        idle();
        chk("b2b_busy3", dut.u_sb.busy, 32'h8);
        chk("b2b2_op1", ex_op1, 64'd7);
        chk("b2b2_op2", ex_op2, 64'd5);
        chk("b2b2_valid", ex_valid, 1);
        tick();
        chk("b2b_drain", ex_valid, 0);

        // RAW stall, released by same-cycle writeback bypass.
        issue(5'd3, 5'd0, 5'd0, 3'b001, 5'd0, 1'b0, 32'h3333);
        #1 chk("raw_stall", id_ready, 0);
        tick();
        chk("raw_stall2", id_ready, 0);
        chk("raw_no_issue", ex_valid, 0);
        wb_valid = 1; wb_rd = 5'd3; wb_data = 64'hAA;
        #1 chk("raw_release", id_ready, 1);
        tick();
        idle();
        chk("raw_op1", ex_op1, 64'hAA);
        chk("raw_valid", ex_valid, 1);
        chk("raw_busy_clr", dut.u_sb.busy, 0);
        tick();

        // WAW: second writer of x4 waits for the first writeback.
        issue(5'd0, 5'd0, 5'd0, 3'b000, 5'd4, 1'b1, 32'h4444);
        tick();
        idle();
        tick();
        chk("waw_busy4", dut.u_sb.busy, 32'h10);
        issue(5'd0, 5'd0, 5'd0, 3'b000, 5'd4, 1'b1, 32'h4445);
        #1 chk("waw_stall", id_ready, 0);
        tick();
        chk("waw_stall2", id_ready, 0);
        wb_valid = 1; wb_rd = 5'd4; wb_data = 64'h1;
        #1 chk("waw_stall_wb", id_ready, 0);
        tick();
        wb_valid = 0;
        #1 chk("waw_release", id_ready, 1);
        chk("waw_busy_clr", dut.u_sb.busy, 0);
        tick();
        idle();
        wb_valid = 1; wb_rd = 5'd4;
        tick();
        chk("set_wins", dut.u_sb.busy, 32'h10);
        tick();
        wb_valid = 0;
        chk("waw_final_clr", dut.u_sb.busy, 0);

        // Backpressure: slot holds for three cycles, busy waits for handoff.
        ex_ready = 0;
        issue(5'd1, 5'd0, 5'd0, 3'b001, 5'd5, 1'b1, 32'hC0FFEE);
        #1 chk("bp_ready0", id_ready, 1);
        tick();
        issue(5'd2, 5'd0, 5'd0, 3'b001, 5'd6, 1'b0, 32'h2222);
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("bp%0d_ready", c), id_ready, 0);
            chk($sformatf("bp%0d_valid", c), ex_valid, 1);
            chk($sformatf("bp%0d_op1", c), ex_op1, 64'd5);
            chk($sformatf("bp%0d_ctrl", c), ex_ctrl, 32'hC0FFEE);
            chk($sformatf("bp%0d_busy", c), dut.u_sb.busy, 0);
            tick();
        end
        ex_ready = 1;
        #1 chk("bp_release", id_ready, 1);
        tick();
        idle();
        chk("bp_next_op1", ex_op1, 64'd7);
        chk("bp_next_ctrl", ex_ctrl, 32'h2222);
        chk("bp_busy5", dut.u_sb.busy, 32'h20);
        tick();
        wb_valid = 1; wb_rd = 5'd5;
        tick();
        wb_valid = 0;
        chk("bp_busy_clr", dut.u_sb.busy, 0);

        // Flush of a held slot: no busy set.
        ex_ready = 0;
        issue(5'd0, 5'd0, 5'd0, 3'b000, 5'd7, 1'b1, 32'h77);
        tick();
        issue(5'd1, 5'd0, 5'd0, 3'b001, 5'd0, 1'b0, 32'h78);
        flush = 1;
        #1 chk("flush_ready", id_ready, 0);
        tick();
        idle();
        chk("flush_valid", ex_valid, 0);
        chk("flush_busy", dut.u_sb.busy, 0);

        // Flush coinciding with handoff: execute owns it, busy set.
        issue(5'd0, 5'd0, 5'd0, 3'b000, 5'd8, 1'b1, 32'h88);
        tick();
        idle();
        flush = 1;
        tick();
        flush = 0;
        chk("flush_ho_valid", ex_valid, 0);
        chk("flush_ho_busy", dut.u_sb.busy, 32'h100);

        // x0 writes and writebacks never touch the scoreboard.
        wb_valid = 1; wb_rd = 5'd0; wb_data = 64'h9;
        tick();
        wb_valid = 0;
        chk("wb_x0_busy", dut.u_sb.busy, 32'h100);
        issue(5'd0, 5'd0, 5'd0, 3'b000, 5'd0, 1'b1, 32'h0);
        tick();
        idle();
        tick();
        chk("rd_x0_busy", dut.u_sb.busy, 32'h100);

        // Asynchronous reset mid-stream with a full slot.
        ex_ready = 0;
        issue(5'd1, 5'd0, 5'd0, 3'b001, 5'd9, 1'b1, 32'h99);
        tick();
        chk("mid_valid", ex_valid, 1);
        #3 rst = 0;
        #1;
        chk("mid_rst_valid", ex_valid, 0);
        chk("mid_rst_busy", dut.u_sb.busy, 0);
        chk("mid_rst_op1", ex_op1, 0);
        chk("mid_rst_ctrl", ex_ctrl, 0);
        chk("mid_rst_rd_we", ex_rd_we, 0);
        idle();
        #2 rst = 1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
